// File: rtl/joint_distr_job_ctrl.sv
// Job sequencer for the BOOST joint-distribution PE array: accepts one job, starts the
// array, counts emitted tables, enforces a watchdog and reports a status word.
module joint_distr_job_ctrl #(
  parameter int PE_WIDTH     = 16,
  parameter int BLOCK_WIDTH  = 16,
  parameter int ADDR_WIDTH   = 32,
  parameter int TIMEOUT_W    = 32,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [PE_WIDTH-1:0]     cmd_snp_num,
  input  logic [BLOCK_WIDTH-1:0]  cmd_snp_length,
  input  logic [ADDR_WIDTH-1:0]   cmd_base_addr,
  input  logic [TIMEOUT_W-1:0]    cfg_timeout,
  output logic                    arr_rst,
  output logic                    arr_start,
  output logic [PE_WIDTH-1:0]     arr_snp_num,
  output logic [BLOCK_WIDTH-1:0]  arr_snp_length,
  output logic [ADDR_WIDTH-1:0]   arr_base_addr,
  input  logic                    arr_done,
  input  logic                    arr_table_valid,
  output logic                    busy,
  output logic                    job_done,
  output logic [1:0]              job_status,
  output logic [2*PE_WIDTH-1:0]   job_table_count,
  output logic [TIMEOUT_W-1:0]    job_cycles
);

  localparam int CW = 2 * PE_WIDTH;
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_RUN, S_DRAIN, S_ABORT, S_REPORT
  } state_t;

  typedef enum logic [1:0] {
    ST_OK, ST_MISMATCH, ST_TIMEOUT, ST_INVALID
  } status_t;

  state_t                 state_q, state_d;
  logic                   arr_rst_q, arr_rst_d;
  logic [PE_WIDTH-1:0]    snp_num_q, snp_num_d;
  logic [BLOCK_WIDTH-1:0] snp_len_q, snp_len_d;
  logic [ADDR_WIDTH-1:0]  base_q, base_d;
  logic [TIMEOUT_W-1:0]   timeout_q, timeout_d;
  logic [CW-1:0]          exp_q, exp_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [TIMEOUT_W-1:0]   cyc_q, cyc_d;
  logic [DW-1:0]          drain_q, drain_d;
  logic                   abort_q, abort_d;
  status_t                rpt_status_q, rpt_status_d;
  logic [CW-1:0]          rpt_count_q, rpt_count_d;
  logic [TIMEOUT_W-1:0]   rpt_cycles_q, rpt_cycles_d;

  status_t                status_next;
  logic [CW-1:0]          prod;
  logic [PE_WIDTH-1:0]    snp_num_m1;
  logic [TIMEOUT_W-1:0]   cyc_inc;

  assign cmd_ready       = (state_q == S_IDLE) && !arr_rst_q;
  assign arr_rst         = arr_rst_q;
  assign arr_start       = (state_q == S_START);
  assign arr_snp_num     = snp_num_q;
  assign arr_snp_length  = snp_len_q;
  assign arr_base_addr   = base_q;
  assign busy            = (state_q != S_IDLE);
  assign job_done        = (state_q == S_REPORT);
  assign job_status      = rpt_status_q;
  assign job_table_count = rpt_count_q;
  assign job_cycles      = rpt_cycles_q;

  assign snp_num_m1 = snp_num_q - PE_WIDTH'(1);
  assign prod       = {{PE_WIDTH{1'b0}}, snp_num_q} * {{PE_WIDTH{1'b0}}, snp_num_m1};
  assign cyc_inc    = (cyc_q == '1) ? cyc_q : cyc_q + TIMEOUT_W'(1);

  always_comb begin
    state_d      = state_q;
    snp_num_d    = snp_num_q;
    snp_len_d    = snp_len_q;
    base_d       = base_q;
    timeout_d    = timeout_q;
    exp_d        = exp_q;
    cyc_d        = cyc_q;
    drain_d      = drain_q;
    abort_d      = abort_q;
    rpt_status_d = rpt_status_q;
    rpt_count_d  = rpt_count_q;
    rpt_cycles_d = rpt_cycles_q;
    status_next  = ST_OK;

    // Tables are counted while the array may still emit them; done-cycle tables included.
    cnt_d = cnt_q;
    if (arr_table_valid && (cnt_q != '1) &&
        (state_q == S_START || state_q == S_RUN || state_q == S_DRAIN))
      cnt_d = cnt_q + CW'(1);

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          snp_num_d = cmd_snp_num;
          snp_len_d = cmd_snp_length;
          base_d    = cmd_base_addr;
          timeout_d = cfg_timeout;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_d = '0;
        cyc_d = '0;
        exp_d = prod >> 1;
        if (snp_num_q < PE_WIDTH'(2) || snp_len_q == '0) begin
          status_next = ST_INVALID;
          state_d     = S_REPORT;
        end else begin
          state_d = S_START;
        end
      end
      S_START: begin
        cyc_d   = TIMEOUT_W'(1);
        state_d = S_RUN;
      end
      S_RUN: begin
        if (arr_done) begin
          cyc_d   = cyc_inc;
          drain_d = DW'(DRAIN_CYCLES - 1);
          state_d = S_DRAIN;
        end else if (timeout_q != '0 && cyc_q == timeout_q) begin
          abort_d = 1'b0;
          state_d = S_ABORT;
        end else begin
          cyc_d = cyc_inc;
        end
      end
      S_DRAIN: begin
        if (drain_q == '0) begin
          status_next = (cnt_d == exp_q) ? ST_OK : ST_MISMATCH;
          state_d     = S_REPORT;
        end else begin
          drain_d = drain_q - DW'(1);
        end
      end
      S_ABORT: begin
        if (abort_q) begin
          status_next = ST_TIMEOUT;
          state_d     = S_REPORT;
        end else begin
          abort_d = 1'b1;
        end
      end
      S_REPORT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    if (state_d == S_REPORT && state_q != S_REPORT) begin
      rpt_status_d = status_next;
      rpt_count_d  = cnt_d;
      rpt_cycles_d = cyc_d;
    end

    arr_rst_d = (state_d == S_ABORT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      arr_rst_q    <= 1'b1;
      snp_num_q    <= '0;
      snp_len_q    <= '0;
      base_q       <= '0;
      timeout_q    <= '0;
      exp_q        <= '0;
      cnt_q        <= '0;
      cyc_q        <= '0;
      drain_q      <= '0;
      abort_q      <= 1'b0;
      rpt_status_q <= ST_OK;
      rpt_count_q  <= '0;
      rpt_cycles_q <= '0;
    end else begin
      state_q      <= state_d;
      arr_rst_q    <= arr_rst_d;
      snp_num_q    <= snp_num_d;
      snp_len_q    <= snp_len_d;
      base_q       <= base_d;
      timeout_q    <= timeout_d;
      exp_q        <= exp_d;
      cnt_q        <= cnt_d;
      cyc_q        <= cyc_d;
      drain_q      <= drain_d;
      abort_q      <= abort_d;
      rpt_status_q <= rpt_status_d;
      rpt_count_q  <= rpt_count_d;
      rpt_cycles_q <= rpt_cycles_d;
    end
  end

endmodule

// File: tb/tb_joint_distr_job_ctrl.sv
// Bench for joint_distr_job_ctrl: table of jobs run against a scripted array model,
// with a scoreboard of expected reports, plus reset / back-to-back sequences.
module tb_joint_distr_job_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_snp_num;
  logic [15:0] cmd_snp_length;
  logic [31:0] cmd_base_addr;
  logic [31:0] cfg_timeout;
  logic        arr_rst;
  logic        arr_start;
  logic [15:0] arr_snp_num;
  logic [15:0] arr_snp_length;
  logic [31:0] arr_base_addr;
  logic        arr_done;
  logic        arr_table_valid;
  logic        busy;
  logic        job_done;
  logic [1:0]  job_status;
  logic [31:0] job_table_count;
  logic [31:0] job_cycles;

  joint_distr_job_ctrl #(
    .PE_WIDTH(16), .BLOCK_WIDTH(16), .ADDR_WIDTH(32), .TIMEOUT_W(32), .DRAIN_CYCLES(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_snp_num(cmd_snp_num), .cmd_snp_length(cmd_snp_length),
    .cmd_base_addr(cmd_base_addr), .cfg_timeout(cfg_timeout),
    .arr_rst(arr_rst), .arr_start(arr_start),
    .arr_snp_num(arr_snp_num), .arr_snp_length(arr_snp_length),
    .arr_base_addr(arr_base_addr),
    .arr_done(arr_done), .arr_table_valid(arr_table_valid),
    .busy(busy), .job_done(job_done), .job_status(job_status),
    .job_table_count(job_table_count), .job_cycles(job_cycles)
  );

  always #5 clk = ~clk;

  // Array script: valids on cycles 0..nv-1 (cycle 0 = START), done on done_at (0 = never),
  // optional extra valid late_k cycles after done.
  typedef struct {
    int n; int l; int t; int nv; int done_at; int late_k;
    int st; int cnt; int cyc;
  } vec_t;

  typedef struct {
    logic [1:0]  st;
    logic [31:0] cnt;
    logic [31:0] cyc;
  } exp_t;

  vec_t vt[15];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic pop_compare(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_err++;
      $display("FAIL %s sb_empty: got job_done with no job pending, expected none", tag);
    end else begin
      e = sb.pop_front();
      check({tag, " status"}, 64'(job_status), 64'(e.st));
      check({tag, " count"},  64'(job_table_count), 64'(e.cnt));
      check({tag, " cycles"}, 64'(job_cycles), 64'(e.cyc));
    end
  endtask

  task automatic wait_ready(input string tag);
    int k = 0;
    while (!cmd_ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (!cmd_ready) begin
      n_checks++;
      n_err++;
      $display("FAIL %s ready_wait: cmd_ready=0 after 40 cycles, expected 1", tag);
    end
  endtask

  task automatic run_job(input vec_t v, input int idx);
    exp_t  e;
    string tag;
    bit    invalid, timed_out, seen;
    int    exp_c, done_c, n_start, start_c, n_rst;
    logic [31:0] addr;
    tag       = $sformatf("v%0d", idx);
    invalid   = (v.n < 2) || (v.l == 0);
    timed_out = !invalid && v.t != 0 && (v.done_at == 0 || v.done_at > v.t);
    exp_c     = invalid ? 0 : (timed_out ? v.t + 3 : v.done_at + 5);
    addr      = 32'h1000_0000 + 32'(idx) * 32'h40;
    seen = 0; done_c = -1; n_start = 0; start_c = -1; n_rst = 0;

    @(negedge clk);
    wait_ready(tag);
    cmd_valid      = 1'b1;
    cmd_snp_num    = 16'(v.n);
    cmd_snp_length = 16'(v.l);
    cmd_base_addr  = addr;
    cfg_timeout    = 32'(v.t);
    e.st = 2'(v.st); e.cnt = 32'(v.cnt); e.cyc = 32'(v.cyc);
    sb.push_back(e);

    @(negedge clk);
    cmd_valid = 1'b0;
    check({tag, " load_busy"},  64'(busy), 64'd1);
    check({tag, " load_ready"}, 64'(cmd_ready), 64'd0);
    check({tag, " arr_snp_num"}, 64'(arr_snp_num), 64'(v.n));
    check({tag, " arr_snp_length"}, 64'(arr_snp_length), 64'(v.l));
    check({tag, " arr_base_addr"}, 64'(arr_base_addr), 64'(addr));

    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (arr_start) begin
        n_start++;
        if (start_c < 0) start_c = c;
      end
      if (arr_rst) n_rst++;
      if (job_done) begin
        seen   = 1;
        done_c = c;
        pop_compare(tag);
      end
      arr_table_valid = (c < v.nv) || (v.late_k != 0 && c == v.done_at + v.late_k);
      arr_done        = (v.done_at != 0) && (c == v.done_at);
      if (seen) break;
    end

    @(negedge clk);
    arr_table_valid = 1'b0;
    arr_done        = 1'b0;
    if (!seen) begin
      n_checks++;
      n_err++;
      $display("FAIL %s job_done_wait: no job_done within 600 cycles, expected one", tag);
    end else begin
      check({tag, " done_latency"}, 64'(done_c), 64'(exp_c));
    end
    check({tag, " done_width"}, 64'(job_done), 64'd0);
    check({tag, " status_hold"}, 64'(job_status), 64'(v.st));
    check({tag, " idle_ready"}, 64'(cmd_ready), 64'd1);
    check({tag, " start_count"}, 64'(n_start), invalid ? 64'd0 : 64'd1);
    if (!invalid) check({tag, " start_cycle"}, 64'(start_c), 64'd0);
    check({tag, " arr_rst_cycles"}, 64'(n_rst), timed_out ? 64'd2 : 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation time limit reached, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err + 1);
    $fatal(1, "timeout");
  end

  initial begin
    //           n   l   t   nv  dn  lk  st  cnt cyc
    vt[0]  = '{  4,  2,  0,  6,  6,  0,  0,  6,  7};
    vt[1]  = '{  4,  2,  0,  5,  5,  0,  1,  5,  6};
    vt[2]  = '{  4,  2,  0,  5,  5,  3,  0,  6,  6};
    vt[3]  = '{  4,  2,  0,  5,  5,  4,  0,  6,  6};
    vt[4]  = '{  4,  2,  0,  6,  5,  0,  0,  6,  6};
    vt[5]  = '{  3,  1,  0,  4,  4,  0,  1,  4,  5};
    vt[6]  = '{  2,  1,  0,  1,  1,  0,  0,  1,  2};
    vt[7]  = '{ 10,  3,  0, 45, 45,  0,  0, 45, 46};
    vt[8]  = '{ 10,  3,  0, 44, 50,  0,  1, 44, 51};
    vt[9]  = '{  4,  2,100,  3,  0,  0,  2,  3,100};
    vt[10] = '{  3,  1, 10,  3, 10,  0,  0,  3, 11};
    vt[11] = '{  3,  1, 10,  3, 11,  0,  2,  3, 10};
    vt[12] = '{  1,  5,  0,  1,  0,  0,  3,  0,  0};
    vt[13] = '{  4,  0,  0,  1,  0,  0,  3,  0,  0};
    vt[14] = '{  0,  3,  0,  1,  0,  0,  3,  0,  0};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_snp_num = '0; cmd_snp_length = '0;
    cmd_base_addr = '0; cfg_timeout = '0; arr_done = 1'b0; arr_table_valid = 1'b0;

    repeat (3) @(negedge clk);
    check("rst arr_rst", 64'(arr_rst), 64'd1);
    check("rst cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst job_done", 64'(job_done), 64'd0);
    check("rst arr_start", 64'(arr_start), 64'd0);
    check("rst job_status", 64'(job_status), 64'd0);
    rst_n = 1'b1;
    #1;
    check("rst_release ready_before_clk", 64'(cmd_ready), 64'd0);
    @(negedge clk);
    check("rst_release arr_rst", 64'(arr_rst), 64'd0);
    check("rst_release cmd_ready", 64'(cmd_ready), 64'd1);

    for (int i = 0; i < 15; i++) run_job(vt[i], i);

    // Back-to-back invalid jobs with cmd_valid held.
    @(negedge clk);
    wait_ready("b2b");
    cmd_valid = 1'b1; cmd_snp_num = 16'd1; cmd_snp_length = 16'd1; cfg_timeout = '0;
    sb.push_back('{2'd3, 32'd0, 32'd0});
    sb.push_back('{2'd3, 32'd0, 32'd0});
    @(negedge clk);
    check("b2b load1_busy", 64'(busy), 64'd1);
    check("b2b load1_ready", 64'(cmd_ready), 64'd0);
    @(negedge clk);
    check("b2b rep1_done", 64'(job_done), 64'd1);
    check("b2b rep1_ready", 64'(cmd_ready), 64'd0);
    if (job_done) pop_compare("b2b job1");
    @(negedge clk);
    check("b2b idle_ready", 64'(cmd_ready), 64'd1);
    check("b2b idle_busy", 64'(busy), 64'd0);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("b2b load2_busy", 64'(busy), 64'd1);
    check("b2b load2_start", 64'(arr_start), 64'd0);
    @(negedge clk);
    check("b2b rep2_done", 64'(job_done), 64'd1);
    check("b2b rep2_arr_rst", 64'(arr_rst), 64'd0);
    if (job_done) pop_compare("b2b job2");

    // Reset asserted mid-RUN: job is dropped with no report.
    @(negedge clk);
    wait_ready("midrst");
    cmd_valid = 1'b1; cmd_snp_num = 16'd4; cmd_snp_length = 16'd2; cfg_timeout = '0;
    cmd_base_addr = 32'hABCD_0000;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    arr_table_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst running", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst arr_rst", 64'(arr_rst), 64'd1);
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst arr_snp_num", 64'(arr_snp_num), 64'd0);
    check("midrst job_count", 64'(job_table_count), 64'd0);
    arr_table_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int jd = 0;
      for (int k = 0; k < 12; k++) begin
        @(negedge clk);
        if (job_done) jd++;
      end
      check("midrst no_job_done", 64'(jd), 64'd0);
    end
    check("midrst sb_empty", 64'(sb.size()), 64'd0);
    run_job(vt[0], 100);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
    $finish;
  end

endmodule
